// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port, clear control and FSM debug.
// A read or write is accepted on any rising edge where rd_en/wr_en is high and clr_busy is low. rd_valid marks rd_data1/2 as loaded by the read accepted on the last edge.
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [WIDTH-1:0]  rd_data1;
  logic [WIDTH-1:0]  rd_data2;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              clr_req;
  logic              clr_busy;
  logic              dbg_sweep;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data1, rd_data2, rd_valid, clr_busy, dbg_sweep
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    output rd_data1, rd_data2, rd_valid, clr_busy, dbg_sweep
  );
endinterface

// File: rtl/regfile_param.sv
// Register file with one write and two registered read ports, optional write bypass,
// optional hardwired zero entry, and a one-entry-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst_n,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data1;
  logic [WIDTH-1:0]  r_rd_data2;
  logic              r_rd_valid;

  logic              w_idle;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [WIDTH-1:0]  w_rd1;
  logic [WIDTH-1:0]  w_rd2;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_acc = w_idle && bus.wr_en &&
                    !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign w_rd_acc = w_idle && bus.rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clr_req) w_next_state = ST_SWEEP;
      ST_SWEEP: if (r_ptr == ADDR_W'(DEPTH - 1)) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (bus.clr_req) begin
      r_ptr <= '0;
    end
  end

  // The sweep owns the array; upstream writes are dropped while it runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero entry wins over bypass, so the forwarding check sits before it.
  always_comb begin
    w_rd1 = r_mem[bus.rd_addr1];
    w_rd2 = r_mem[bus.rd_addr2];
    if ((BYPASS != 0) && w_wr_acc && (bus.wr_addr == bus.rd_addr1)) w_rd1 = bus.wr_data;
    if ((BYPASS != 0) && w_wr_acc && (bus.wr_addr == bus.rd_addr2)) w_rd2 = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) w_rd1 = '0;
    if ((ZERO_REG != 0) && (bus.rd_addr2 == '0)) w_rd2 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data1 <= w_rd1;
        r_rd_data2 <= w_rd2;
      end
    end
  end

  assign bus.rd_data1  = r_rd_data1;
  assign bus.rd_data2  = r_rd_data2;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.clr_busy  = (r_state == ST_SWEEP);
  assign bus.dbg_sweep = (r_state == ST_SWEEP);
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, and neither) share one
// stimulus stream and are compared against an array-based reference model.
module tb_regfile_param;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr1 = '0;
  logic [ADDR_W-1:0] rd_addr2 = '0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              clr_req = 1'b0;

  regfile_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_a ();
  regfile_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.rd_en = rd_en;       assign bus_b.rd_en = rd_en;
  assign bus_a.rd_addr1 = rd_addr1; assign bus_b.rd_addr1 = rd_addr1;
  assign bus_a.rd_addr2 = rd_addr2; assign bus_b.rd_addr2 = rd_addr2;
  assign bus_a.wr_en = wr_en;       assign bus_b.wr_en = wr_en;
  assign bus_a.wr_addr = wr_addr;   assign bus_b.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;   assign bus_b.wr_data = wr_data;
  assign bus_a.clr_req = clr_req;   assign bus_b.clr_req = clr_req;

  regfile_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  regfile_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: a = ZERO_REG/BYPASS on, b = both off
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  int               sweep_left;
  logic             exp_v, exp_busy;
  logic [WIDTH-1:0] exp_a1, exp_a2, exp_b1, exp_b2;

  wire [131:0] obs_all = {bus_a.rd_valid, bus_a.rd_data1, bus_a.rd_data2, bus_a.clr_busy,
                          bus_b.rd_valid, bus_b.rd_data1, bus_b.rd_data2, bus_b.clr_busy};
  wire [131:0] exp_all = {exp_v, exp_a1, exp_a2, exp_busy, exp_v, exp_b1, exp_b2, exp_busy};

  function automatic logic [WIDTH-1:0] ref_read(input bit zr, input bit bp,
                                                input logic [WIDTH-1:0] stored,
                                                input logic [ADDR_W-1:0] a);
    if (zr && a == 0) return '0;
    if (bp && wr_en && wr_addr == a) return wr_data;
    return stored;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    sweep_left = 0;
    exp_v = 1'b0; exp_busy = 1'b0;
    exp_a1 = '0; exp_a2 = '0; exp_b1 = '0; exp_b2 = '0;
  endtask

  // Advance model by one edge using the current inputs, then the clock.
  task automatic tick();
    if (sweep_left > 0) begin
      mem_a[DEPTH - sweep_left] = '0;
      mem_b[DEPTH - sweep_left] = '0;
      sweep_left--;
      exp_v = 1'b0;
    end else begin
      exp_v = rd_en;
      if (rd_en) begin
        exp_a1 = ref_read(1, 1, mem_a[rd_addr1], rd_addr1);
        exp_a2 = ref_read(1, 1, mem_a[rd_addr2], rd_addr2);
        exp_b1 = ref_read(0, 0, mem_b[rd_addr1], rd_addr1);
        exp_b2 = ref_read(0, 0, mem_b[rd_addr2], rd_addr2);
      end
      if (wr_en && wr_addr != 0) mem_a[wr_addr] = wr_data;
      if (wr_en) mem_b[wr_addr] = wr_data;
      if (clr_req) sweep_left = DEPTH;
    end
    exp_busy = (sweep_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_all !== '0 || bus_a.dbg_sweep !== 1'b0) begin
      errors++;
      $display("FAIL reset obs=%h dbg=%b exp=0", obs_all, bus_a.dbg_sweep);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_all_zero();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr1 = ADDR_W'(a); rd_addr2 = ADDR_W'(DEPTH - 1 - a);
      tick();
      checks++;
      if (obs_all !== exp_all || bus_a.rd_valid !== 1'b1 || bus_b.rd_data1 !== '0) begin
        errors++;
        $display("FAIL read_zero addr=%0d obs=%h exp=%h", a, obs_all, exp_all);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (obs_all !== exp_all || bus_a.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_hold obs=%h exp=%h", obs_all, exp_all);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; tick();
    wr_addr = 5'd31; wr_data = 32'h12345678; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd31; tick();
    checks++;
    if ({bus_a.rd_data1, bus_a.rd_data2, bus_b.rd_data1, bus_b.rd_data2} !==
        {32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678} || obs_all !== exp_all) begin
      errors++;
      $display("FAIL write_read a=%h/%h b=%h/%h exp=deadbeef/12345678", bus_a.rd_data1,
               bus_a.rd_data2, bus_b.rd_data1, bus_b.rd_data2);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd0; tick();
    checks++;
    if ({bus_a.rd_data1, bus_a.rd_data2, bus_b.rd_data1, bus_b.rd_data2} !==
        {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL zero_reg a=%h/%h b=%h/%h exp=0/0 ffffffff/ffffffff", bus_a.rd_data1,
               bus_a.rd_data2, bus_b.rd_data1, bus_b.rd_data2);
    end
    wr_en = 1'b1; wr_data = 32'h11111111; tick();
    checks++;
    if ({bus_a.rd_data1, bus_a.rd_data2, bus_b.rd_data1} !== {32'h0, 32'h0, 32'hFFFFFFFF} ||
        obs_all !== exp_all) begin
      errors++;
      $display("FAIL zero_reg_bypass a=%h/%h b=%h exp=0/0 ffffffff", bus_a.rd_data1,
               bus_a.rd_data2, bus_b.rd_data1);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h01010101; tick();
    wr_data = 32'hA5A5A5A5; rd_en = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd7; tick();
    checks++;
    if ({bus_a.rd_data1, bus_a.rd_data2, bus_b.rd_data1, bus_b.rd_data2} !==
        {32'hA5A5A5A5, 32'hA5A5A5A5, 32'h01010101, 32'h01010101}) begin
      errors++;
      $display("FAIL bypass_same_edge a=%h b=%h exp=a5a5a5a5 01010101", bus_a.rd_data1,
               bus_b.rd_data1);
    end
    wr_en = 1'b0; tick();
    checks++;
    if ({bus_a.rd_data1, bus_b.rd_data1, bus_b.rd_data2} !==
        {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL bypass_next_read a=%h b=%h exp=a5a5a5a5", bus_a.rd_data1, bus_b.rd_data1);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(8 + i); wr_data = $urandom;
      rd_en = 1'b1; rd_addr1 = ADDR_W'(8 + i); rd_addr2 = ADDR_W'(7 + i);
      tick();
      checks++;
      if (obs_all !== exp_all || bus_a.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back i=%0d obs=%h exp=%h", i, obs_all, exp_all);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      wr_en = 1'($urandom_range(0, 1));
      rd_addr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_addr2 = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr1 : ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL random i=%0d obs=%h exp=%h", i, obs_all, exp_all);
      end
    end
    idle_inputs();
  endtask

  task automatic fill_nonzero();
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_addr = ADDR_W'(i); wr_data = 32'h01010101 * (i + 1);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cycles;
    fill_nonzero();
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0003;
    rd_en = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    tick();
    checks++;
    if (obs_all !== exp_all || bus_a.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_start obs=%h exp=%h", obs_all, exp_all);
    end
    busy_cycles = 0;
    while (bus_a.clr_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      clr_req = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
      rd_addr1 = ADDR_W'($urandom_range(0, DEPTH - 1)); rd_addr2 = rd_addr1;
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); wr_data = $urandom;
      tick();
      checks++;
      if (obs_all !== exp_all || bus_a.rd_valid !== 1'b0 || bus_b.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_sweep cyc=%0d obs=%h exp=%h", busy_cycles, obs_all, exp_all);
      end
    end
    checks++;
    if (busy_cycles !== 32) begin
      errors++;
      $display("FAIL clear_busy_len got=%0d exp=32", busy_cycles);
    end
    idle_inputs();
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_en = 1'b1; rd_addr1 = ADDR_W'(2 * i); rd_addr2 = ADDR_W'(2 * i + 1);
      tick();
      checks++;
      if (obs_all !== exp_all || {bus_b.rd_data1, bus_b.rd_data2} !== 64'h0) begin
        errors++;
        $display("FAIL clear_readback i=%0d obs=%h exp=%h", i, obs_all, exp_all);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    fill_nonzero();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.clr_busy !== 1'b0 || bus_b.clr_busy !== 1'b0 || bus_a.dbg_sweep !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset busy_a=%b busy_b=%b exp=0", bus_a.clr_busy, bus_b.clr_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_en = 1'b1; rd_addr1 = ADDR_W'(DEPTH - 1 - i); rd_addr2 = ADDR_W'(i);
      tick();
      checks++;
      if (obs_all !== exp_all || {bus_b.rd_data1, bus_b.rd_data2} !== 64'h0 ||
          bus_b.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL mid_sweep_readback i=%0d obs=%h exp=%h", i, obs_all, exp_all);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
